// File: rtl/fpcvt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpcvt_pkg
// Description : Shared widths, limits and the packed result type for the
//               12-bit integer to 8-bit sign/magnitude float converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpcvt_pkg;

    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
    localparam logic [SIG_W-1:0] SIG_MAX = 4'hF;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [SIG_W-1:0] f;
    } fp8_t;

endpackage
`default_nettype wire

// File: rtl/fpcvt_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpcvt_lzc
// Description : Priority encoder over magnitude bits M[10:4]. It yields the
//               exponent and the right shift that aligns the leading one to
//               the top of the significand. M[3:0] never raises the exponent,
//               so those bits are not inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fpcvt_lzc
    import fpcvt_pkg::*;
(
    input  logic [6:0]       m_hi,
    output logic [EXP_W-1:0] exp,
    output logic [2:0]       shamt
);

    // Ascending scan, so the highest set bit is the one that sticks.
    always_comb begin
        exp   = '0;
        shamt = '0;
        for (int i = 0; i < 7; i++) begin
            if (m_hi[i]) begin
                exp   = 3'(i + 1);
                shamt = 3'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpcvt.sv
`default_nettype none
// ============================================================================
// Module      : fpcvt
// Description : Registered conversion of a 12-bit two's-complement integer
//               into {S, E[2:0], F[3:0]}, value = (-1)^S * F * 2^E.
//               Build option FPCVT_ROUND_EN selects round-half-up; without
//               it the significand is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  D,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [SIG_W-1:0] F
);

    logic             w_s;
    logic [IN_W-1:0]  w_mag;
    logic [EXP_W-1:0] w_exp_raw;
    logic [2:0]       w_shamt;
    logic [SIG_W-1:0] w_f_win;
    logic [SIG_W-1:0] w_f_raw;
    fp8_t             w_res;
    fp8_t             r_res;

    assign w_s   = D[IN_W-1];
    assign w_mag = w_s ? ((~D) + 12'd1) : D;

    fpcvt_lzc u_lzc (
        .m_hi  (w_mag[10:4]),
        .exp   (w_exp_raw),
        .shamt (w_shamt)
    );

    // Shifting M[10:1] by shamt places M[p:p-3] in the low four bits.
    assign w_f_win = 4'(w_mag[10:1] >> w_shamt);
    assign w_f_raw = (w_exp_raw == '0) ? w_mag[3:0] : w_f_win;

    always_comb begin
        w_res.s = w_s;
        w_res.e = w_exp_raw;
        w_res.f = w_f_raw;
`ifdef FPCVT_ROUND_EN
        // Round bit M[p-4] sits exactly at index shamt.
        if ((w_exp_raw != '0) && w_mag[w_shamt]) begin
            if (w_f_raw == SIG_MAX) begin
                if (w_exp_raw == EXP_MAX) begin
                    w_res.f = SIG_MAX;
                end else begin
                    w_res.e = w_exp_raw + 3'd1;
                    w_res.f = 4'b1000;
                end
            end else begin
                w_res.f = w_f_raw + 4'd1;
            end
        end
`endif
        // Only -2048 reaches bit 11 of the magnitude.
        if (w_mag[IN_W-1]) begin
            w_res.e = EXP_MAX;
            w_res.f = SIG_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_res;
        end
    end

    assign S = r_res.s;
    assign E = r_res.e;
    assign F = r_res.f;

endmodule
`default_nettype wire

// File: tb/tb_fpcvt.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpcvt
// Description : Self-checking bench for fpcvt: directed cases, then a
//               shuffled sweep of all 4096 inputs with random reset pulses,
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpcvt;

    logic        clk;
    logic        rst_n;
    logic [11:0] D;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    int n_checks;
    int n_fail;

    fpcvt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .S     (S),
        .E     (E),
        .F     (F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Value-level model: find the smallest E with |D| < 16*2^E, divide, round.
    function automatic logic [7:0] ref_cvt(input logic [11:0] d);
        int v, mag, e, f, rem;
        logic sgn;
        v   = int'($signed(d));
        sgn = (v < 0);
        mag = sgn ? -v : v;
        if (mag >= 2048) return {1'b1, 3'd7, 4'hF};
        e = 0;
        while (mag >= (16 << e)) e++;
        f   = mag >> e;
        rem = mag - (f << e);
`ifdef FPCVT_ROUND_EN
        if (e > 0 && 2 * rem >= (1 << e)) f++;
        if (f == 16) begin
            if (e == 7) f = 15;
            else begin
                f = 8;
                e++;
            end
        end
`endif
        return {sgn, 3'(e), 4'(f)};
    endfunction

    // Drive away from the rising edge, sample 1 time unit after it.
    task automatic step(input logic [11:0] d, input logic r);
        @(negedge clk);
        D     = d;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dut_word();
        return {S, E, F};
    endfunction

    function automatic int err_ok(input logic [11:0] d, input logic [7:0] w);
        int v, mag, val, err, bound, e;
        v   = int'($signed(d));
        mag = (v < 0) ? -v : v;
        e   = int'(w[6:4]);
        val = int'(w[3:0]) << e;
        err = (val > mag) ? val - mag : mag - val;
        if (w[6:0] == 7'h7F) return 1;
`ifdef FPCVT_ROUND_EN
        bound = (e == 0) ? 0 : (1 << (e - 1));
`else
        bound = (e == 0) ? 0 : (1 << e) - 1;
`endif
        return (err <= bound) ? 1 : 0;
    endfunction

    logic [11:0] order [4096];
    logic [11:0] tmp;
    int          j;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        D        = 12'h599;
        rst_n    = 1'b0;

        step(12'h599, 1'b0);
        check("reset_edge1", 32'(dut_word()), 32'h00);
        step(12'h599, 1'b0);
        check("reset_edge2", 32'(dut_word()), 32'h00);
        step(12'h000, 1'b1);
        check("zero", 32'(dut_word()), 32'h00);

        step(12'b010110011001, 1'b1);
        check("pos_r0", 32'(dut_word()), 32'h7B);
        step(12'b101001110010, 1'b1);
        check("neg_r0", 32'(dut_word()), 32'hFB);
`ifdef FPCVT_ROUND_EN
        step(12'b010101011111, 1'b1);
        check("round_up", 32'(dut_word()), 32'h7B);
        step(12'b001111100000, 1'b1);
        check("renorm", 32'(dut_word()), 32'h78);
`else
        step(12'b010101011111, 1'b1);
        check("trunc", 32'(dut_word()), 32'h7A);
        step(12'b001111100000, 1'b1);
        check("trunc_e6", 32'(dut_word()), 32'h6F);
`endif
        step(12'b011111111111, 1'b1);
        check("sat_pos", 32'(dut_word()), 32'h7F);
        step(12'b100000000000, 1'b1);
        check("sat_min", 32'(dut_word()), 32'hFF);
        step(12'hFFF, 1'b1);
        check("minus_one", 32'(dut_word()), 32'h81);
        step(12'd13, 1'b1);
        check("e0_exact", 32'(dut_word()), 32'h0D);
        step(12'h7FF, 1'b0);
        check("mid_reset", 32'(dut_word()), 32'h00);

        for (int i = 0; i < 4096; i++) order[i] = 12'(i);
        for (int i = 4095; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end

        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(63, 0) == 0) begin
                step(order[i], 1'b0);
                check("sweep_reset", 32'(dut_word()), 32'h00);
            end
            step(order[i], 1'b1);
            check("sweep", 32'(dut_word()), 32'(ref_cvt(order[i])));
            check("sweep_err", 32'(err_ok(order[i], dut_word())), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
